// File: rtl/rc_pkg.sv
// Shared types and constants for the remote_comm host command link.
package rc_pkg;

  localparam logic [7:0] POS_ACK = 8'hA5;
  localparam logic [7:0] ACK     = 8'h5A;

  localparam int BAUD_DIV_DEF = 2604;
  localparam int BAUD_W_DEF   = 12;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  function automatic logic is_ack(input logic [7:0] b);
    return (b == POS_ACK) || (b == ACK);
  endfunction

endpackage

// File: rtl/remote_comm_if.sv
// Command/response bundle between the host bench and remote_comm, plus FSM debug taps.
interface remote_comm_if;
  import rc_pkg::*;

  // send_cmd is a request sampled with cmd; it is taken only while tx_state is IDLE
  // (otherwise dropped, never queued). cmd_sent and resp_rdy are levels, not pulses.
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        tx_busy;
  logic        TX;
  logic        RX;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        resp_err;
  tx_state_t   tx_state;
  rx_state_t   rx_state;

  modport master (
    output cmd, send_cmd, RX,
    input  cmd_sent, tx_busy, TX, resp, resp_rdy, resp_err, tx_state, rx_state
  );

  modport slave (
    input  cmd, send_cmd, RX,
    output cmd_sent, tx_busy, TX, resp, resp_rdy, resp_err, tx_state, rx_state
  );

endinterface

// File: rtl/rc_uart_rx.sv
// UART byte receiver: 2-flop synchroniser, mid-bit sampler, stop-bit framing check.
// REMOTE_COMM_RESP_CHK_EN adds the ack-byte check on resp_err.
module rc_uart_rx
  import rc_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int BAUD_W   = BAUD_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] resp,
  output logic       resp_rdy,
  output logic       resp_err,
  output rx_state_t  state
);

  localparam logic [BAUD_W-1:0] FULL = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BAUD_W-1:0] HALF = BAUD_W'(BAUD_DIV / 2 - 1);

  logic [1:0]        sync;
  logic              rx_s;
  logic              rx_d;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic              byte_ok;

  assign rx_s    = sync[1];
  assign byte_ok = (state == RX_STOP) && (baud_cnt == FULL) && rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= 2'b11;
      rx_d     <= 1'b1;
      state    <= RX_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      resp     <= '0;
      resp_rdy <= 1'b0;
    end else begin
      sync <= {sync[0], rx};
      rx_d <= rx_s;
      case (state)
        RX_IDLE: begin
          if (rx_d && !rx_s) begin
            state    <= RX_START;
            baud_cnt <= '0;
            resp_rdy <= 1'b0;
          end
        end
        RX_START: begin
          if (baud_cnt == HALF) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (baud_cnt == FULL) begin
            baud_cnt <= '0;
            shift    <= {rx_s, shift[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= RX_STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (baud_cnt == FULL) begin
            baud_cnt <= '0;
            state    <= RX_IDLE;
            // A low stop bit is a framing error: the byte is dropped silently.
            if (rx_s) begin
              resp     <= shift;
              resp_rdy <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

`ifdef REMOTE_COMM_RESP_CHK_EN
  always_ff @(posedge clk) begin
    if (rst)          resp_err <= 1'b0;
    else if (byte_ok) resp_err <= !is_ack(shift);
  end
`else
  assign resp_err = 1'b0;
`endif

endmodule

// File: rtl/remote_comm.sv
// Host command link: sends a 16-bit command as two UART bytes (high first) and
// receives the one-byte robot reply. REMOTE_COMM_RESP_CHK_EN enables resp_err.
module remote_comm
  import rc_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEF,
  parameter int BAUD_W   = BAUD_W_DEF
) (
  input logic         clk,
  input logic         rst,
  remote_comm_if.slave bus
);

  localparam logic [BAUD_W-1:0] FULL = BAUD_W'(BAUD_DIV - 1);

  tx_state_t         state;
  logic [7:0]        shadow_lo;
  logic [8:0]        shift;
  logic [3:0]        bit_cnt;
  logic [BAUD_W-1:0] baud_cnt;

  assign bus.tx_state = state;

  // The start bit is driven on the acceptance edge, so the two frames take exactly 20 bit times.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      shadow_lo    <= '0;
      shift        <= '1;
      bit_cnt      <= '0;
      baud_cnt     <= '0;
      bus.TX       <= 1'b1;
      bus.cmd_sent <= 1'b0;
      bus.tx_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.send_cmd) begin
            shadow_lo    <= bus.cmd[7:0];
            shift        <= {1'b1, bus.cmd[15:8]};
            bit_cnt      <= '0;
            baud_cnt     <= '0;
            bus.TX       <= 1'b0;
            bus.cmd_sent <= 1'b0;
            bus.tx_busy  <= 1'b1;
            state        <= HIGH;
          end
        end
        HIGH, LOW: begin
          if (baud_cnt == FULL) begin
            baud_cnt <= '0;
            if (bit_cnt == 4'd9) begin
              bit_cnt <= '0;
              if (state == HIGH) begin
                shift  <= {1'b1, shadow_lo};
                bus.TX <= 1'b0;
                state  <= LOW;
              end else begin
                bus.TX       <= 1'b1;
                bus.cmd_sent <= 1'b1;
                bus.tx_busy  <= 1'b0;
                state        <= IDLE;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              bus.TX  <= shift[0];
              shift   <= {1'b1, shift[8:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rc_uart_rx #(
    .BAUD_DIV(BAUD_DIV),
    .BAUD_W  (BAUD_W)
  ) u_rx (
    .clk     (clk),
    .rst     (rst),
    .rx      (bus.RX),
    .resp    (bus.resp),
    .resp_rdy(bus.resp_rdy),
    .resp_err(bus.resp_err),
    .state   (bus.rx_state)
  );

endmodule

// File: tb/tb_remote_comm.sv
// Directed bench for remote_comm: TX framing/latency, ignored requests, RX replies,
// framing errors, ack check and mid-frame reset.
module tb_remote_comm;
  import rc_pkg::*;

  localparam int BD = 32;
  localparam int BW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  remote_comm_if bus();

  remote_comm #(.BAUD_DIV(BD), .BAUD_W(BW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] tx_exp_q[$];
  logic [8:0] rx_exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err(input logic [7:0] b);
`ifdef REMOTE_COMM_RESP_CHK_EN
    return !(b == 8'hA5 || b == 8'h5A);
`else
    return 1'b0;
`endif
  endfunction

  // Called at a negedge; returns at the negedge right after the acceptance edge.
  task automatic accept_cmd(input logic [15:0] c);
    bus.cmd      = c;
    bus.send_cmd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.send_cmd = 1'b0;
  endtask

  task automatic do_send(input logic [15:0] c, input int inject_at, input logic hold_end);
    logic [7:0] got [2];
    int bit_i;
    int fr;
    got[0] = '0;
    got[1] = '0;
    tx_exp_q.push_back(c[15:8]);
    tx_exp_q.push_back(c[7:0]);
    accept_cmd(c);
    for (int i = 0; i < 20 * BD; i++) begin
      bit_i = (i / BD) % 10;
      fr    = i / (10 * BD);
      if (i == inject_at) begin
        bus.cmd      = 16'hFFFF;
        bus.send_cmd = 1'b1;
      end else if (i == inject_at + 1) begin
        bus.send_cmd = 1'b0;
      end
      if (hold_end && i == 20 * BD - 1) bus.send_cmd = 1'b1;
      check("tx_busy_high", 32'(bus.tx_busy), 32'd1);
      check("cmd_sent_low", 32'(bus.cmd_sent), 32'd0);
      if (i % BD == BD / 2) begin
        if (bit_i == 0)      check("start_bit", 32'(bus.TX), 32'd0);
        else if (bit_i == 9) check("stop_bit", 32'(bus.TX), 32'd1);
        else                 got[fr][bit_i-1] = bus.TX;
      end
      if (i < 20 * BD - 1) @(negedge clk);
    end
    @(posedge clk);
    #1;
    check("cmd_sent_at_20bd", 32'(bus.cmd_sent), 32'd1);
    check("tx_busy_done", 32'(bus.tx_busy), 32'd0);
    check("tx_idle_line", 32'(bus.TX), 32'd1);
    check("tx_state_idle", 32'(bus.tx_state), 32'(IDLE));
    bus.send_cmd = 1'b0;
    for (int f = 0; f < 2; f++) begin
      if (tx_exp_q.size() == 0) check("tx_q_underflow", 32'd1, 32'd0);
      else check("tx_byte", 32'(got[f]), 32'(tx_exp_q.pop_front()));
    end
    @(negedge clk);
    check("cmd_sent_hold", 32'(bus.cmd_sent), 32'd1);
    check("tx_state_still_idle", 32'(bus.tx_state), 32'(IDLE));
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop);
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      bus.RX = 1'b0;
      else if (k == 9) bus.RX = stop;
      else             bus.RX = b[k-1];
      repeat (BD) @(negedge clk);
    end
    bus.RX = 1'b1;
  endtask

  task automatic watch_rx(input logic valid);
    logic       seen;
    logic [8:0] e;
    seen = 1'b0;
    repeat (4) @(negedge clk);
    check("rdy_clear_on_start", 32'(bus.resp_rdy), 32'd0);
    for (int i = 4; i < 10 * BD + 4 && !seen; i++) begin
      @(negedge clk);
      if (bus.resp_rdy) seen = 1'b1;
    end
    check("resp_rdy_seen", 32'(seen), 32'(valid));
    if (valid && rx_exp_q.size() > 0) begin
      e = rx_exp_q.pop_front();
      if (seen) begin
        check("resp_byte", 32'(bus.resp), 32'(e[7:0]));
        check("resp_err", 32'(bus.resp_err), 32'(e[8]));
      end
    end
  endtask

  task automatic rx_case(input logic [7:0] b, input logic stop);
    if (stop) rx_exp_q.push_back({exp_err(b), b});
    fork
      drive_rx(b, stop);
      watch_rx(stop);
    join
    repeat (2 * BD) @(negedge clk);
  endtask

  initial begin
    bus.cmd      = '0;
    bus.send_cmd = 1'b0;
    bus.RX       = 1'b1;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(bus.TX), 32'd1);
    check("rst_cmd_sent", 32'(bus.cmd_sent), 32'd0);
    check("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
    check("rst_resp", 32'(bus.resp), 32'h00);
    check("rst_resp_rdy", 32'(bus.resp_rdy), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_tx_state", 32'(bus.tx_state), 32'(IDLE));
    check("rst_rx_state", 32'(bus.rx_state), 32'(RX_IDLE));
    rst = 1'b0;
    @(negedge clk);

    // Command with a mid-transfer request and a request on the completion cycle.
    do_send(16'h2000, 200, 1'b1);

    // Robot reply model, then framing error, recovery and a non-ack byte.
    rx_case(8'hA5, 1'b1);
    rx_case(8'h5A, 1'b0);
    check("rdy_after_bad_stop", 32'(bus.resp_rdy), 32'd0);
    rx_case(8'h5A, 1'b1);
    rx_case(8'h3C, 1'b1);

    // Reset in the middle of the high-byte frame.
    accept_cmd(16'h1234);
    repeat (3 * BD) @(negedge clk);
    check("mid_frame_state", 32'(bus.tx_state), 32'(HIGH));
    check("mid_frame_tx", 32'(bus.TX), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_tx", 32'(bus.TX), 32'd1);
    check("mrst_tx_busy", 32'(bus.tx_busy), 32'd0);
    check("mrst_cmd_sent", 32'(bus.cmd_sent), 32'd0);
    check("mrst_resp_rdy", 32'(bus.resp_rdy), 32'd0);
    check("mrst_resp", 32'(bus.resp), 32'h00);
    check("mrst_resp_err", 32'(bus.resp_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_send(16'h00C3, -1, 1'b0);

    check("tx_q_drained", 32'(tx_exp_q.size()), 32'd0);
    check("rx_q_drained", 32'(rx_exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
